// File: rtl/fw_version_pkt_arbiter.sv
// Round-robin arbiter that hands the firmware version to one of two requesters per packet,
// serialising a 7-byte metadata packet. Define FW_VERSION_PKT_TIMEOUT_EN for the stall watchdog.
module fw_version_pkt_arbiter #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  META_TYPE      = 8'h01,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt,
  output logic [1:0] o_done,
  input  logic [7:0] i_ver_major,
  input  logic [7:0] i_ver_minor,
  input  logic [7:0] i_ver_patch,
  output logic [7:0] o_m_data,
  output logic       o_m_valid,
  input  logic       i_m_ready,
  output logic       o_m_last,
  output logic       o_busy,
  output logic       o_abort
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     r_state, w_state;
  logic [2:0] r_idx, w_idx;
  logic       r_valid, w_valid;
  logic       r_id, w_id;
  logic       r_last_id, w_last_id;
  logic [7:0] r_major, w_major;
  logic [7:0] r_minor, w_minor;
  logic [7:0] r_patch, w_patch;
  logic [1:0] r_gnt, w_gnt;
  logic [1:0] r_done, w_done;
  logic [3:0] r_gap_cnt, w_gap_cnt;
  logic       w_arb;
  logic       w_win;
  logic       w_finish;
  logic [7:0] w_sum;
  logic [7:0] w_byte;

`ifdef FW_VERSION_PKT_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_stall, w_stall;
  logic        r_abort, w_abort;
`endif

  // Both requesting: serve whoever was not served last; otherwise the lone requester.
  assign w_win = (i_req == 2'b11) ? ~r_last_id : i_req[1];

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_valid   = r_valid;
    w_id      = r_id;
    w_last_id = r_last_id;
    w_major   = r_major;
    w_minor   = r_minor;
    w_patch   = r_patch;
    w_gnt     = 2'b00;
    w_done    = 2'b00;
    w_gap_cnt = r_gap_cnt;
    w_arb     = 1'b0;
    w_finish  = 1'b0;
`ifdef FW_VERSION_PKT_TIMEOUT_EN
    w_stall   = r_stall;
    w_abort   = 1'b0;
`endif
    case (r_state)
      IDLE: w_arb = 1'b1;
      SEND: begin
        if (r_valid && i_m_ready) begin
`ifdef FW_VERSION_PKT_TIMEOUT_EN
          w_stall = 16'd0;
`endif
          if (r_idx == 3'd6) begin
            w_finish       = 1'b1;
            w_done[r_id]   = 1'b1;
          end else begin
            w_idx = r_idx + 3'd1;
          end
        end
`ifdef FW_VERSION_PKT_TIMEOUT_EN
        else if (r_valid) begin
          if (r_stall == STALL_LAST) begin
            w_finish = 1'b1;
            w_abort  = 1'b1;
            w_stall  = 16'd0;
          end else begin
            w_stall = r_stall + 16'd1;
          end
        end
`endif
      end
      // The final gap cycle arbitrates so the grant lands right after the last gap cycle.
      GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_arb = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt + 4'd1;
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_finish) begin
      w_valid   = 1'b0;
      w_gap_cnt = 4'd0;
      w_state   = (GAP_CYCLES == 0) ? IDLE : GAP;
    end

    if (w_arb) begin
      w_state = IDLE;
      if (|i_req) begin
        w_state      = SEND;
        w_gnt[w_win] = 1'b1;
        w_valid      = 1'b1;
        w_idx        = 3'd0;
        w_id         = w_win;
        w_last_id    = w_win;
        w_major      = i_ver_major;
        w_minor      = i_ver_minor;
        w_patch      = i_ver_patch;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_idx     <= 3'd0;
      r_valid   <= 1'b0;
      r_id      <= 1'b0;
      r_last_id <= 1'b1;
      r_major   <= 8'd0;
      r_minor   <= 8'd0;
      r_patch   <= 8'd0;
      r_gnt     <= 2'b00;
      r_done    <= 2'b00;
      r_gap_cnt <= 4'd0;
`ifdef FW_VERSION_PKT_TIMEOUT_EN
      r_stall   <= 16'd0;
      r_abort   <= 1'b0;
`endif
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_valid   <= w_valid;
      r_id      <= w_id;
      r_last_id <= w_last_id;
      r_major   <= w_major;
      r_minor   <= w_minor;
      r_patch   <= w_patch;
      r_gnt     <= w_gnt;
      r_done    <= w_done;
      r_gap_cnt <= w_gap_cnt;
`ifdef FW_VERSION_PKT_TIMEOUT_EN
      r_stall   <= w_stall;
      r_abort   <= w_abort;
`endif
    end
  end

  // Checksum makes all seven bytes sum to zero mod 256.
  assign w_sum = SYNC_BYTE + META_TYPE + {7'd0, r_id} + r_major + r_minor + r_patch;

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = META_TYPE;
      3'd2:    w_byte = {7'd0, r_id};
      3'd3:    w_byte = r_major;
      3'd4:    w_byte = r_minor;
      3'd5:    w_byte = r_patch;
      3'd6:    w_byte = 8'h00 - w_sum;
      default: w_byte = 8'h00;
    endcase
  end

  assign o_gnt     = r_gnt;
  assign o_done    = r_done;
  assign o_m_valid = r_valid;
  assign o_m_data  = r_valid ? w_byte : 8'h00;
  assign o_m_last  = r_valid && (r_idx == 3'd6);
  assign o_busy    = (r_state != IDLE);
`ifdef FW_VERSION_PKT_TIMEOUT_EN
  assign o_abort   = r_abort;
`else
  assign o_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_fw_version_pkt_arbiter.sv
// Self-checking bench: packet-level reference model compared every cycle, plus directed
// literal packet checks and a randomized soak.
module tb_fw_version_pkt_arbiter;

  localparam int unsigned GAP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       rdy = 1'b0;
  logic [7:0] maj = 8'd0;
  logic [7:0] mnr = 8'd0;
  logic [7:0] pat = 8'd0;

  logic [1:0] o_gnt, o_done;
  logic [7:0] o_m_data;
  logic       o_m_valid, o_m_last, o_busy, o_abort;

  always #5 clk = ~clk;

  fw_version_pkt_arbiter #(
    .SYNC_BYTE     (8'hA5),
    .META_TYPE     (8'h01),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(1024)
  ) u_dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req),
    .o_gnt      (o_gnt),
    .o_done     (o_done),
    .i_ver_major(maj),
    .i_ver_minor(mnr),
    .i_ver_patch(pat),
    .o_m_data   (o_m_data),
    .o_m_valid  (o_m_valid),
    .i_m_ready  (rdy),
    .o_m_last   (o_m_last),
    .o_busy     (o_busy),
    .o_abort    (o_abort)
  );

  // Reference model: the whole packet is built as a byte array at grant time.
  typedef struct packed {
    logic            active;
    logic [2:0]      pos;
    logic [4:0]      wt;
    logic            last;
    logic            id;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [6:0][7:0] pkt;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r      = '0;
    r.last = 1'b1;
    return r;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input logic [1:0] rq, input logic rd,
                                    input logic [7:0] a, input logic [7:0] b,
                                    input logic [7:0] c);
    mdl_t       n;
    logic [7:0] sum;
    logic       w;
    n      = s;
    n.gnt  = 2'b00;
    n.done = 2'b00;
    if (s.active) begin
      if (rd) begin
        if (s.pos == 3'd6) begin
          n.active    = 1'b0;
          n.done[s.id] = 1'b1;
          n.wt        = 5'(GAP);
        end else begin
          n.pos = s.pos + 3'd1;
        end
      end
    end else if (s.wt > 5'd1) begin
      n.wt = s.wt - 5'd1;
    end else begin
      n.wt = 5'd0;
      if (rq != 2'b00) begin
        w        = (rq == 2'b11) ? !s.last : rq[1];
        n.pkt[0] = 8'hA5;
        n.pkt[1] = 8'h01;
        n.pkt[2] = {7'd0, w};
        n.pkt[3] = a;
        n.pkt[4] = b;
        n.pkt[5] = c;
        sum      = 8'd0;
        for (int k = 0; k < 6; k++) sum = sum + n.pkt[k];
        n.pkt[6] = 8'h00 - sum;
        n.active = 1'b1;
        n.pos    = 3'd0;
        n.id     = w;
        n.last   = w;
        n.gnt[w] = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= mdl_reset();
    else     mdl <= mdl_step(mdl, req, rdy, maj, mnr, pat);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", 32'(o_m_valid), 32'(mdl.active));
      chk("data", 32'(o_m_data), mdl.active ? 32'(mdl.pkt[mdl.pos]) : 32'd0);
      chk("last", 32'(o_m_last), 32'(mdl.active && (mdl.pos == 3'd6)));
      chk("gnt", 32'(o_gnt), 32'(mdl.gnt));
      chk("done", 32'(o_done), 32'(mdl.done));
      chk("busy", 32'(o_busy), 32'(mdl.active || (mdl.wt != 5'd0)));
`ifndef FW_VERSION_PKT_TIMEOUT_EN
      chk("abort", 32'(o_abort), 32'd0);
`endif
    end
  end

  logic [7:0] cap_q[$];
  int         gaps[$];
  int         low_run;
  int         done_cnt;
  logic [1:0] done_acc;

  task automatic clear_obs();
    cap_q.delete();
    gaps.delete();
    low_run  = 0;
    done_cnt = 0;
    done_acc = 2'b00;
  endtask

  task automatic step_cyc();
    @(negedge clk);
    if (!o_m_valid) begin
      low_run++;
    end else begin
      if (low_run != 0 && cap_q.size() > 0) gaps.push_back(low_run);
      low_run = 0;
    end
    if (o_m_valid && rdy) cap_q.push_back(o_m_data);
    done_cnt += int'(o_done[0]) + int'(o_done[1]);
    done_acc |= o_done;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while (done_cnt < n && c < budget) begin
      step_cyc();
      c++;
    end
    chk(nm, 32'(done_cnt), 32'(n));
  endtask

  task automatic chk_byte(input string nm, input int idx, input logic [7:0] exp);
    chk(nm, (idx < cap_q.size()) ? 32'(cap_q[idx]) : 32'hDEAD, 32'(exp));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step_cyc();
    rst = 1'b0;
  endtask

  logic [7:0] pkt_v11 [7] = '{8'hA5, 8'h01, 8'h00, 8'h0B, 8'h01, 8'h01, 8'h4D};

  task automatic chk_pkt_v11(input string nm);
    chk(nm, 32'(cap_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) chk_byte(nm, i, pkt_v11[i]);
  endtask

  initial begin
    int c;
    #1 rst = 1'b1;
    step_cyc();
    chk("rst_data", 32'(o_m_data), 32'd0);
    chk("rst_valid", 32'(o_m_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    step_cyc();
    rst = 1'b0;
    repeat (2) step_cyc();

    // Single requester, version 11.1.1, no back-pressure.
    maj = 8'h0B; mnr = 8'h01; pat = 8'h01; rdy = 1'b1;
    clear_obs();
    req = 2'b01;
    run_until_done(1, 30, "t1_done");
    req = 2'b00;
    chk_pkt_v11("t1_pkt");
    chk("t1_back_to_back", 32'(gaps.size()), 32'd0);
    chk("t1_done_who", 32'(done_acc), 32'd1);
    repeat (4) step_cyc();

    // Both requesting from reset: req0, req1, req0 with exact gaps.
    pulse_reset();
    repeat (2) step_cyc();
    clear_obs();
    req = 2'b11;
    run_until_done(3, 80, "t2_done");
    req = 2'b00;
    repeat (4) step_cyc();
    chk("t2_len", 32'(cap_q.size()), 32'd21);
    chk_byte("t2_id0", 2, 8'h00);
    chk_byte("t2_id1", 9, 8'h01);
    chk_byte("t2_id2", 16, 8'h00);
    chk_byte("t2_csum1", 13, 8'h4C);
    chk("t2_ngaps", 32'(gaps.size()), 32'd2);
    chk("t2_gap0", (gaps.size() > 0) ? 32'(gaps[0]) : 32'hDEAD, 32'(GAP));
    chk("t2_gap1", (gaps.size() > 1) ? 32'(gaps[1]) : 32'hDEAD, 32'(GAP));

    // Back-pressure pattern 1,0,0,1 must not change the byte stream.
    clear_obs();
    req = 2'b01;
    c = 0;
    while (done_cnt < 1 && c < 60) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      step_cyc();
      c++;
    end
    chk("t3_done", 32'(done_cnt), 32'd1);
    req = 2'b00;
    rdy = 1'b1;
    chk_pkt_v11("t3_pkt");
    repeat (4) step_cyc();

    // Patch changes while byte 2 is on the bus; only the next packet sees it.
    clear_obs();
    req = 2'b01;
    c = 0;
    while (done_cnt < 2 && c < 60) begin
      if (cap_q.size() == 2 && pat == 8'h01) pat = 8'h02;
      step_cyc();
      c++;
    end
    chk("t4_done", 32'(done_cnt), 32'd2);
    req = 2'b00;
    chk_byte("t4_patch_a", 5, 8'h01);
    chk_byte("t4_csum_a", 6, 8'h4D);
    chk_byte("t4_patch_b", 12, 8'h02);
    chk_byte("t4_csum_b", 13, 8'h4C);
    pat = 8'h01;
    repeat (4) step_cyc();

    // Reset while byte 3 is on the bus.
    clear_obs();
    req = 2'b01;
    c = 0;
    while (cap_q.size() < 3 && c < 20) begin
      step_cyc();
      c++;
    end
    chk("t5_reach_b3", 32'(cap_q.size()), 32'd3);
    rst = 1'b1;
    #1;
    chk("t5_valid_now", 32'(o_m_valid), 32'd0);
    chk("t5_busy_now", 32'(o_busy), 32'd0);
    req = 2'b00;
    step_cyc();
    rst = 1'b0;
    repeat (3) step_cyc();
    chk("t5_no_done", 32'(done_acc), 32'd0);
    clear_obs();
    req = 2'b01;
    run_until_done(1, 30, "t5_redone");
    req = 2'b00;
    chk_pkt_v11("t5_pkt");
    repeat (4) step_cyc();

    // Randomized soak against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) maj = 8'($urandom);
      if ($urandom_range(0, 15) == 0) mnr = 8'($urandom);
      if ($urandom_range(0, 15) == 0) pat = 8'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      step_cyc();
    end
    rst = 1'b0;
    req = 2'b00;
    repeat (4) step_cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
